// File: rtl/gmii_phy_speed_ctrl_if.sv
// Signal bundle between the GMII PHY speed controller and its surroundings:
// the MDIO pad (mdc / mdio_i / mdio_o / mdio_t), the poll controls, and the
// resolved link status that feeds the PHY interface and the MAC.
// The master modport is the controller's view. The slave modport is the
// view of whatever drives the controls and consumes the status.
interface gmii_phy_speed_ctrl_if;
    logic       enable;
    logic       poll_req;
    logic       mdc;
    logic       mdio_i;
    logic       mdio_o;
    logic       mdio_t;
    logic       mii_select;
    logic [1:0] speed;
    logic       link_up;
    logic       full_duplex;
    logic       status_valid;
    logic       read_err;

    modport master (
        input  enable, poll_req, mdio_i,
        output mdc, mdio_o, mdio_t,
        output mii_select, speed, link_up, full_duplex, status_valid, read_err
    );

    modport slave (
        output enable, poll_req, mdio_i,
        input  mdc, mdio_o, mdio_t,
        input  mii_select, speed, link_up, full_duplex, status_valid, read_err
    );
endinterface

// File: rtl/gmii_phy_speed_ctrl.sv
// gmii_phy_speed_ctrl
// Periodically reads a PHY's resolved-status register with a Clause 22 MDIO
// read. It then drives mii_select, speed, link_up and full_duplex for the
// GMII PHY interface and the MAC.
// Frame: 32 preamble ones, 14 command bits, 2 turnaround bits, 16 data bits,
// then one UPDATE cycle. Each bit period is 2*MDC_DIV clk cycles, with mdc
// low for the first half.
// Optional build macro SPEED_DEBOUNCE_EN: a link-up decode is applied only
// when it repeats the previous valid decode.
module gmii_phy_speed_ctrl #(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter logic [4:0] STATUS_REG    = 5'h11,
    parameter int         MDC_DIV       = 20,
    parameter int         POLL_INTERVAL = 125000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gmii_phy_speed_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(2 * MDC_DIV);
    localparam int TMR_W = $clog2(POLL_INTERVAL);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(MDC_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * MDC_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_INTERVAL - 1);

    // Global bit index within the 64-bit frame at which each phase ends.
    localparam logic [5:0] BIT_PRE_END  = 6'd31;
    localparam logic [5:0] BIT_CMD_END  = 6'd45;
    localparam logic [5:0] BIT_TA_END   = 6'd47;
    localparam logic [5:0] BIT_DATA_END = 6'd63;

    // Start(01), read opcode(10), PHY address, register address; sent MSB first.
    // Padded to 16 bits so any 4-bit select stays in range.
    localparam logic [15:0] CMD_WORD = {2'b00, 2'b01, 2'b10, PHY_ADDR, STATUS_REG};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CMD,
        S_TA,
        S_DATA,
        S_UPDATE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [5:0]       bit_idx, bit_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [15:0]      shreg, shreg_n;
    logic             ta_fail;
    logic             active_n;
    logic             mdc_n, mdio_o_n, mdio_t_n;
    logic [3:0]       cmd_sel;

    logic             mdc_q, mdio_o_q, mdio_t_q;
    logic             mii_select_q, link_q, duplex_q, valid_q, err_q;
    logic [1:0]       speed_q;
    logic             link_ok, reserved, stable;

    // Next-state logic: poll timer, bit timing, data capture, turnaround check.
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        timer_n = timer;
        shreg_n = shreg;
        ta_fail = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.poll_req || (bus.enable && timer == TMR_LAST)) begin
                    state_n = S_PRE;
                    cnt_n   = '0;
                    bit_n   = '0;
                    timer_n = '0;
                end else if (bus.enable) begin
                    timer_n = timer + 1'b1;
                end else begin
                    timer_n = '0;
                end
            end

            S_PRE, S_CMD, S_TA, S_DATA: begin
                cnt_n = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == CNT_HALF && state == S_DATA) begin
                    shreg_n = {shreg[14:0], bus.mdio_i};
                end
                // The PHY must pull the second turnaround bit low. A high
                // bit here means nobody answered.
                if (cnt == CNT_HALF && bit_idx == BIT_TA_END && bus.mdio_i) begin
                    ta_fail = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    bit_n = bit_idx + 1'b1;
                    case (bit_idx)
                        BIT_PRE_END:  state_n = S_CMD;
                        BIT_CMD_END:  state_n = S_TA;
                        BIT_TA_END:   state_n = S_DATA;
                        BIT_DATA_END: state_n = S_UPDATE;
                        default:      ;
                    endcase
                end
            end

            S_UPDATE: state_n = S_IDLE;

            default: state_n = S_IDLE;
        endcase

        // Pad outputs are computed from the next state and then registered.
        // This keeps mdc and mdio glitch-free, and mdio_o only moves at a bit start.
        active_n = state_n inside {S_PRE, S_CMD, S_TA, S_DATA};
        mdc_n    = active_n && (cnt_n >= CNT_HALF);
        mdio_t_n = !(state_n == S_PRE || state_n == S_CMD);
        cmd_sel  = 4'(BIT_CMD_END - bit_n);
        mdio_o_n = (state_n == S_CMD) ? CMD_WORD[cmd_sel] : 1'b1;
    end

    // Frame sequencer and MDIO pad registers. A reset mid-frame releases the bus at once.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            timer    <= '0;
            shreg    <= '0;
            mdc_q    <= 1'b0;
            mdio_o_q <= 1'b1;
            mdio_t_q <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            timer    <= timer_n;
            shreg    <= shreg_n;
            mdc_q    <= mdc_n;
            mdio_o_q <= mdio_o_n;
            mdio_t_q <= mdio_t_n;
        end
    end

    assign link_ok  = shreg[11] && shreg[10];
    assign reserved = (shreg[15:14] == 2'b11);

`ifdef SPEED_DEBOUNCE_EN
    logic [2:0] held;
    logic       held_vld;
    assign stable = held_vld && (held == shreg[15:13]);
`else
    assign stable = 1'b1;
`endif

    // Status outputs: updated from the captured word in UPDATE, or by a failed turnaround.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mii_select_q <= 1'b0;
            speed_q      <= 2'b10;
            link_q       <= 1'b0;
            duplex_q     <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
`ifdef SPEED_DEBOUNCE_EN
            held         <= '0;
            held_vld     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (ta_fail) begin
                err_q  <= 1'b1;
                link_q <= 1'b0;
`ifdef SPEED_DEBOUNCE_EN
                held_vld <= 1'b0;
`endif
            end else if (state == S_UPDATE) begin
                if (!link_ok) begin
                    link_q  <= 1'b0;
                    valid_q <= 1'b1;
`ifdef SPEED_DEBOUNCE_EN
                    held_vld <= 1'b0;
`endif
                end else if (reserved) begin
                    err_q <= 1'b1;
`ifdef SPEED_DEBOUNCE_EN
                    held_vld <= 1'b0;
`endif
                end else begin
                    if (stable) begin
                        speed_q      <= shreg[15:14];
                        duplex_q     <= shreg[13];
                        link_q       <= 1'b1;
                        mii_select_q <= (shreg[15:14] != 2'b10);
                        valid_q      <= 1'b1;
                    end
`ifdef SPEED_DEBOUNCE_EN
                    held     <= shreg[15:13];
                    held_vld <= 1'b1;
`endif
                end
            end
        end
    end

    assign bus.mdc          = mdc_q;
    assign bus.mdio_o       = mdio_o_q;
    assign bus.mdio_t       = mdio_t_q;
    assign bus.mii_select   = mii_select_q;
    assign bus.speed        = speed_q;
    assign bus.link_up      = link_q;
    assign bus.full_duplex  = duplex_q;
    assign bus.status_valid = valid_q;
    assign bus.read_err     = err_q;

endmodule

// File: tb/tb_gmii_phy_speed_ctrl.sv
// Testbench for gmii_phy_speed_ctrl. The MDIO PHY model answers reads with
// phy_data, or leaves the line pulled high when phy_present is 0. Each poll
// pushes its expected outcome onto a queue. The entry is popped and compared
// once the frame's result window has elapsed.
module tb_gmii_phy_speed_ctrl;
    localparam int MDC_DIV   = 2;
    localparam int POLL      = 100;
    localparam int FRAME_LAT = 128 * MDC_DIV + 1;
    localparam int TA_LAT    = 47 * 2 * MDC_DIV + MDC_DIV + 1;

    typedef enum {K_VALID, K_ERR, K_NONE} kind_e;
    typedef struct {
        kind_e      kind;
        int         latency;
        logic [1:0] speed;
        logic       mii_select;
        logic       link_up;
        logic       full_duplex;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    gmii_phy_speed_ctrl_if bus();

    gmii_phy_speed_ctrl #(
        .PHY_ADDR     (5'd3),
        .STATUS_REG   (5'h11),
        .MDC_DIV      (MDC_DIV),
        .POLL_INTERVAL(POLL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PHY model: tracks the bit index from mdc falling edges and captures the command bits
    logic        phy_present = 1'b1;
    logic [15:0] phy_data    = 16'hAC00;
    int          phy_bit     = 0;
    logic        mdc_q       = 1'b0;
    logic        t_q         = 1'b1;
    int          rises       = 0;
    logic [13:0] cmd_cap     = '0;
    logic        pre_bad     = 1'b0;
    int          last_rise_cyc = 0;
    int          mdc_period  = 0;
    logic        mdio_model;

    always @(posedge clk) begin
        mdc_q <= bus.mdc;
        t_q   <= bus.mdio_t;
        if (t_q && !bus.mdio_t) begin
            phy_bit <= 0;
            rises   <= 0;
            cmd_cap <= '0;
            pre_bad <= 1'b0;
        end else begin
            if (mdc_q && !bus.mdc) phy_bit <= phy_bit + 1;
            if (!mdc_q && bus.mdc) begin
                rises         <= rises + 1;
                mdc_period    <= cyc - last_rise_cyc;
                last_rise_cyc <= cyc;
                if (phy_bit >= 32 && phy_bit <= 45) cmd_cap <= {cmd_cap[12:0], bus.mdio_o};
                if (phy_bit < 32 && !bus.mdio_o) pre_bad <= 1'b1;
            end
        end
    end

    always_comb begin
        mdio_model = 1'b1;
        if (phy_present) begin
            if (phy_bit == 47) mdio_model = 1'b0;
            else if (phy_bit >= 48 && phy_bit <= 63) mdio_model = phy_data[4'(63 - phy_bit)];
        end
    end
    assign bus.mdio_i = mdio_model;

    // Reference state of the outputs, plus the debounce memory
    exp_t       sb[$];
    logic [1:0] m_speed = 2'b10;
    logic       m_mii   = 1'b0;
    logic       m_link  = 1'b0;
    logic       m_dup   = 1'b0;
    logic       m_held_vld = 1'b0;
    logic [2:0] m_held  = '0;
    int         start_cyc = 0;
    int         last_err_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_speed = 2'b10; m_mii = 1'b0; m_link = 1'b0; m_dup = 1'b0;
        m_held_vld = 1'b0; m_held = '0;
        sb.delete();
    endtask

    task automatic push_expect(input logic [15:0] d, input logic present);
        exp_t e;
        e.kind = K_VALID;
        e.latency = FRAME_LAT;
        if (!present) begin
            m_link = 1'b0; m_held_vld = 1'b0;
            e.kind = K_ERR; e.latency = TA_LAT;
        end else if (!d[11] || !d[10]) begin
            m_link = 1'b0; m_held_vld = 1'b0;
        end else if (d[15:14] == 2'b11) begin
            m_held_vld = 1'b0;
            e.kind = K_ERR;
        end else begin
`ifdef SPEED_DEBOUNCE_EN
            if (!(m_held_vld && m_held == d[15:13])) e.kind = K_NONE;
            m_held = d[15:13]; m_held_vld = 1'b1;
`endif
            if (e.kind == K_VALID) begin
                m_speed = d[15:14]; m_dup = d[13]; m_link = 1'b1;
                m_mii = (d[15:14] != 2'b10);
            end
        end
        e.speed = m_speed; e.mii_select = m_mii; e.link_up = m_link; e.full_duplex = m_dup;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mdc"},    bus.mdc, 1'b0);
        check({tag, "_mdio_o"}, bus.mdio_o, 1'b1);
        check({tag, "_mdio_t"}, bus.mdio_t, 1'b1);
        check({tag, "_mii"},    bus.mii_select, 1'b0);
        check({tag, "_speed"},  bus.speed, 2'b10);
        check({tag, "_link"},   bus.link_up, 1'b0);
        check({tag, "_dup"},    bus.full_duplex, 1'b0);
        check({tag, "_sv"},     bus.status_valid, 1'b0);
        check({tag, "_err"},    bus.read_err, 1'b0);
    endtask

    // Waits (bounded) for the controller to start driving MDIO and records that cycle
    task automatic wait_start(input string tag, input int budget);
        int found = 0;
        for (int i = 0; i <= budget; i++) begin
            if (!bus.mdio_t) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        start_cyc = cyc;
        check({tag, "_started"}, found, 1);
    endtask

    // Watches one frame's result window, then pops and compares the expected outcome
    task automatic run_frame(input string tag, input int midreq_at);
        exp_t e;
        int   budget;
        int   n_sv = 0;
        int   n_re = 0;
        int   first = -1;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        budget = (sb[0].kind == K_NONE) ? FRAME_LAT + 8 : sb[0].latency + 3;
        while (cyc - start_cyc < budget) begin
            @(negedge clk);
            bus.poll_req = (midreq_at > 0 && cyc - start_cyc == midreq_at);
            if (bus.status_valid) begin
                n_sv++;
                if (first < 0) first = cyc - start_cyc;
            end
            if (bus.read_err) begin
                n_re++;
                if (first < 0) first = cyc - start_cyc;
                last_err_cyc = cyc;
            end
        end
        bus.poll_req = 1'b0;
        e = sb.pop_front();
        check({tag, "_sv_pulses"}, n_sv, (e.kind == K_VALID) ? 1 : 0);
        check({tag, "_err_pulses"}, n_re, (e.kind == K_ERR) ? 1 : 0);
        if (e.kind != K_NONE) check({tag, "_latency"}, first, e.latency);
        check({tag, "_outputs"}, {bus.speed, bus.mii_select, bus.link_up, bus.full_duplex},
              {e.speed, e.mii_select, e.link_up, e.full_duplex});
    endtask

    // Requests a poll with enable low, checks the next-cycle start, then checks the result
    task automatic poll(input string tag, input logic [15:0] d, input int midreq_at);
        int req_cyc;
        phy_data = d;
        push_expect(d, phy_present);
        bus.poll_req = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        bus.poll_req = 1'b0;
        wait_start(tag, 4);
        check({tag, "_req_to_start"}, start_cyc - req_cyc, 1);
        run_frame(tag, midreq_at);
    endtask

    initial begin
        int ref_cyc;
        int lows;
        int pulses;
        bus.enable   = 1'b0;
        bus.poll_req = 1'b0;
        rst_n        = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");

        // Timer-driven poll; enable is dropped mid-frame and the frame must still complete
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        ref_cyc    = cyc;
        phy_data   = 16'hAC00;
        push_expect(16'hAC00, 1'b1);
        wait_start("timer", POLL + 50);
        check("timer_start_cycle", start_cyc - ref_cyc, POLL);
        bus.enable = 1'b0;
        run_frame("ac00", 0);
        check("cmd_bits", cmd_cap, 14'b01_10_00011_10001);
        check("mdc_rises", rises, 64);
        check("mdc_period", mdc_period, 2 * MDC_DIV);
        check("preamble_ones", pre_bad, 1'b0);

        // Speed decodes, reserved speed, link loss, and the debounce sequence
        poll("p6c00", 16'h6C00, 0);
        poll("p0c00", 16'h0C00, 0);
        poll("pac00", 16'hAC00, 0);
        poll("pfc00", 16'hFC00, 0);
        poll("pa000", 16'hA000, 0);
        poll("db_ac00", 16'hAC00, 0);
        poll("db_6c00a", 16'h6C00, 0);
        poll("db_6c00b", 16'h6C00, 0);

        // Absent PHY: turnaround failure, then the next timed poll POLL cycles later
        phy_present = 1'b0;
        bus.enable  = 1'b1;
        push_expect(16'h0000, 1'b0);
        wait_start("absent1", POLL + 50);
        run_frame("absent1", 0);
        push_expect(16'h0000, 1'b0);
        wait_start("absent2", POLL + 50);
        check("absent_repoll_gap", start_cyc - last_err_cyc, POLL);
        bus.enable = 1'b0;
        run_frame("absent2", 0);
        phy_present = 1'b1;

        // A poll_req in mid-frame is ignored: exactly one frame
        poll("midreq", 16'h6C00, 50);
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (!bus.mdio_t) lows++;
        end
        check("midreq_no_second_frame", lows, 0);

        // Reset asserted during the DATA phase
        phy_data     = 16'hAC00;
        bus.poll_req = 1'b1;
        @(negedge clk);
        bus.poll_req = 1'b0;
        wait_start("rst_mid", 4);
        while (cyc - start_cyc < 200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.status_valid || bus.read_err || !bus.mdio_t) pulses++;
        end
        check("rst_mid_quiet", pulses, 0);

        poll("after_rst", 16'h0C00, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
